fifo_reader: RTL and testbench
==============================

Name: fifo_reader

Overview:
- Read-side controller for the 16x4 push/pop shift FIFO.
- Drives `pop`, captures the registered `q` one cycle later, and presents words on a valid/ready stream with a 2-entry output buffer.
- Sits between the FIFO and any downstream consumer, so consumers never deal with FIFO read latency or empty timing.

Parameters:
- DATA_W, 4, data width; matches FIFO `d`/`q` width.
- CNT_W, 8, width of the delivered-word counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-low; asserted (0) clears all state immediately.
- enable  in  1  1 = reader may issue pops; 0 = no new pops.
- fifo_empty  in  1  FIFO empty flag.
- fifo_q  in  DATA_W  FIFO read data; valid in the cycle after a pop was issued.
- fifo_pop  out  1  pop request to FIFO.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word when out_valid & out_ready at the clock edge.
- out_data  out  DATA_W  head word of output buffer.
- words_out  out  CNT_W  count of words handed off downstream, wraps.
- busy  out  1  1 while a pop is in flight or the buffer is non-empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: fifo_pop=0, out_valid=0, out_data=0, words_out=0, busy=0.
  - Internal state: buffer occupancy=0, inflight=0.
- State:
  - 2-entry buffer kept in FIFO order (head = oldest), occupancy occ in 0..2.
  - inflight flag = fifo_pop registered.
- Pop issue (combinational):
  - fifo_pop = enable & !fifo_empty & ((occ - take + inflight) < 2), where take = out_valid & out_ready.
  - Guarantees a captured word always has a free slot.
  - Sustains 1 word/cycle when the consumer is always ready.
- Capture: if inflight=1, fifo_q is written into the buffer at the next rising edge, behind any existing entries. Read latency is 1 cycle.
- Output and counting:
  - out_valid = (occ != 0); out_data = head entry.
  - out_data must stay stable while out_valid=1 and out_ready=0.
  - On take: head is removed and words_out increments modulo 2^CNT_W (255 -> 0).
- Simultaneous capture and take in one cycle: occ is unchanged; the new word goes behind the remaining entry. With occ=1 this makes the captured word the new head.
- Latency: FIFO non-empty with buffer empty and enable=1 -> pop in cycle N, capture at edge N+1, out_valid=1 in cycle N+1.
- enable deasserted mid-stream:
  - No new pops from the next evaluation.
  - A word already in flight is still captured.
  - The buffer continues to drain normally.
- fifo_empty=1: no pop. The empty flag is trusted as-is; no speculative pops.
- out_ready held 0: at most 2 buffered words plus 0 in flight; fifo_pop stays 0.
- Reset mid-operation: buffered and in-flight words are discarded. Upon reset release the block restarts from the reset state. The system resets the FIFO together with the reader.
- busy = inflight | (occ != 0).

Decomposition:
- Shared package:
  - DATA_W default.
  - CNT_W default.
  - Buffer depth constant OBUF_DEPTH=2 (hard-coded in the pop-issue comparison).
- One natural sub-module: fifo_reader_obuf.
  - 2-entry ordered buffer with write, take, head data and occupancy.
  - The top holds the pop-issue logic, the inflight flag and the counter.

Test Plan:
- Reset and single word:
  - Stimulus: reset=0 then 1, out_ready=1, FIFO preloaded with 0x5, enable=1.
  - Response: fifo_pop=1 for exactly one cycle; next cycle out_valid=1 with out_data=0x5; words_out=1 after accept; busy returns to 0.
- Streaming:
  - Stimulus: FIFO holds 0x1..0x8, out_ready=1 constant.
  - Response: 8 consecutive out_valid cycles carrying 0x1..0x8 in order; no bubbles after the first; words_out=8.
- Backpressure:
  - Stimulus: FIFO holds 0xA,0xB,0xC; out_ready=0 for 10 cycles, then 1.
  - During stall: only 2 pops issued; out_data stays 0xA.
  - After release: 0xA,0xB,0xC delivered in order; the third pop is issued only once space frees.
- enable drop with word in flight:
  - Stimulus: enable falls in the cycle after a pop of 0x7.
  - Response: 0x7 still captured and delivered; no further pops while enable=0.
- Counter wrap:
  - Stimulus: 256 words delivered.
  - Response: words_out reads 255 then 0.
- Asynchronous reset mid-stream:
  - Stimulus: reset driven low between clock edges with occ=2.
  - Response: out_valid, fifo_pop, words_out and busy go to 0 without waiting for a clock edge; nothing stale is delivered after release.

Source files
------------

// File: rtl/fifo_reader_pkg.sv
// Shared constants and helpers for the FIFO read-side controller and its output buffer.
package fifo_reader_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int CNT_W_DEF  = 8;
    localparam int OBUF_DEPTH = 2;

    // Words that will occupy the buffer after this edge: current entries, minus a take, plus a capture.
    function automatic logic [2:0] pending_words(
        input logic [1:0] occ,
        input logic       take,
        input logic       inflight
    );
        return {1'b0, occ} - {2'b00, take} + {2'b00, inflight};
    endfunction

endpackage

// File: rtl/fifo_reader_obuf.sv
// Two-entry ordered output buffer: writes land behind existing entries, takes remove the head.
module fifo_reader_obuf
    import fifo_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              take,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        occ
);

    logic [DATA_W-1:0] ent0_q;
    logic [DATA_W-1:0] ent0_d;
    logic [DATA_W-1:0] ent1_q;
    logic [DATA_W-1:0] ent1_d;
    logic [1:0]        occ_q;
    logic [1:0]        occ_d;

    // Next-state for entries and occupancy; entry 0 is always the head.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        case ({wr_en, take})
            2'b01: begin
                if (occ_q != 2'd0) begin
                    ent0_d = ent1_q;
                    occ_d  = occ_q - 2'd1;
                end else begin
                    occ_d = occ_q;
                end
            end
            2'b10: begin
                case (occ_q)
                    2'd0: begin
                        ent0_d = wr_data;
                        occ_d  = 2'd1;
                    end
                    2'd1: begin
                        ent1_d = wr_data;
                        occ_d  = 2'd2;
                    end
                    default: begin
                        occ_d = occ_q;
                    end
                endcase
            end
            2'b11: begin
                // Occupancy unchanged; the new word slides in behind whatever remains.
                if (occ_q == 2'd2) begin
                    ent0_d = ent1_q;
                    ent1_d = wr_data;
                end else if (occ_q == 2'd1) begin
                    ent0_d = wr_data;
                end else begin
                    ent0_d = wr_data;
                    occ_d  = 2'd1;
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= {DATA_W{1'b0}};
            ent1_q <= {DATA_W{1'b0}};
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign head_data = ent0_q;
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller: issues FIFO pops, absorbs the one-cycle read latency and presents a valid/ready stream.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_q,
    output logic              fifo_pop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  words_out,
    output logic              busy
);

    logic             inflight_q;
    logic             inflight_d;
    logic [CNT_W-1:0] words_q;
    logic [CNT_W-1:0] words_d;
    logic [1:0]       occ_s;
    logic             take_s;
    logic             pop_s;

    assign take_s = out_valid & out_ready;

    // Pop only when the word it returns is guaranteed a free slot; held off while in reset.
    always_comb begin
        pop_s      = 1'b0;
        inflight_d = 1'b0;
        words_d    = words_q;
        if (reset && enable && !fifo_empty &&
            (pending_words(occ_s, take_s, inflight_q) < 3'(OBUF_DEPTH))) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        inflight_d = pop_s;
        if (take_s) begin
            words_d = words_q + CNT_W'(1);
        end else begin
            words_d = words_q;
        end
    end

    // In-flight flag and delivered-word counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q <= 1'b0;
            words_q    <= {CNT_W{1'b0}};
        end else begin
            inflight_q <= inflight_d;
            words_q    <= words_d;
        end
    end

    fifo_reader_obuf #(
        .DATA_W (DATA_W)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (reset),
        .wr_en     (inflight_q),
        .wr_data   (fifo_q),
        .take      (take_s),
        .head_data (out_data),
        .occ       (occ_s)
    );

    assign fifo_pop  = pop_s;
    assign out_valid = (occ_s != 2'd0);
    assign words_out = words_q;
    assign busy      = inflight_q | (occ_s != 2'd0);

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: queue-based FIFO environment plus a queue-level reference of the output buffer.
module tb_fifo_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    bit         fifo_empty = 1'b1;
    logic [3:0] fifo_q_r = 4'h0;
    logic       fifo_pop;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic [7:0] words_out;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [3:0] fifo[$];
    logic [3:0] ref_buf[$];
    logic       ref_inflight = 1'b0;
    logic [7:0] ref_words = 8'd0;
    bit         pop_pend = 1'b0;
    bit         ref_pop_pend = 1'b0;
    bit         take_pend = 1'b0;

    fifo_reader dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q_r),
        .fifo_pop   (fifo_pop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .words_out  (words_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Expected pop: enough room for every word that will be buffered after this edge.
    function automatic bit exp_pop();
        int pending;
        bit take;
        take    = (ref_buf.size() != 0) && (out_ready === 1'b1);
        pending = ref_buf.size() - (take ? 1 : 0) + (ref_inflight ? 1 : 0);
        return (reset === 1'b1) && (enable === 1'b1) && !fifo_empty && (pending < 2);
    endfunction

    // Decisions for the coming edge, sampled while everything is settled.
    always @(negedge clk) begin
        pop_pend     <= (fifo_pop === 1'b1);
        ref_pop_pend <= exp_pop();
        take_pend    <= (reset === 1'b1) && (ref_buf.size() != 0) && (out_ready === 1'b1);
    end

    // FIFO environment (registered q, registered empty flag) and reference buffer update.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_buf.delete();
            ref_inflight <= 1'b0;
            ref_words    <= 8'd0;
            fifo_q_r     <= 4'h0;
            fifo_empty   <= (fifo.size() == 0);
        end else begin
            if (take_pend) begin
                void'(ref_buf.pop_front());
                ref_words <= ref_words + 8'd1;
            end
            if (ref_inflight) ref_buf.push_back(fifo_q_r);
            ref_inflight <= ref_pop_pend;
            if (pop_pend && fifo.size() != 0) fifo_q_r <= fifo.pop_front();
            fifo_empty <= (fifo.size() == 0);
        end
    end

    task automatic test_reset();
        int pops;
        int got;
        reset = 1'b0; enable = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b want 0", fifo_pop); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
        checks++; if (words_out !== 8'd0) begin errors++; $display("FAIL reset_words: got %0d want 0", words_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b1; enable = 1'b1; out_ready = 1'b1;
        fifo.push_back(4'h5);
        pops = 0; got = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (fifo_pop !== exp_pop()) begin errors++; $display("FAIL single_pop c%0d: got %b want %b", c, fifo_pop, exp_pop()); end
            if (fifo_pop === 1'b1) pops++;
            if (out_valid === 1'b1) begin
                checks++; if (out_data !== 4'h5) begin errors++; $display("FAIL single_data: got %h want 5", out_data); end
                got++;
            end
            @(posedge clk); #1;
        end
        checks++; if (pops != 1) begin errors++; $display("FAIL single_pop_count: got %0d want 1", pops); end
        checks++; if (got != 1) begin errors++; $display("FAIL single_valid_count: got %0d want 1", got); end
        checks++; if (words_out !== 8'd1) begin errors++; $display("FAIL single_words: got %0d want 1", words_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
    endtask

    task automatic test_streaming();
        int first;
        int last;
        int nvalid;
        logic [7:0] w0;
        w0 = ref_words; enable = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) fifo.push_back(4'(i));
        first = -1; last = -1; nvalid = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checks++; if (fifo_pop !== exp_pop()) begin errors++; $display("FAIL stream_pop c%0d: got %b want %b", c, fifo_pop, exp_pop()); end
            checks++; if (out_valid !== (ref_buf.size() != 0)) begin errors++; $display("FAIL stream_valid c%0d: got %b want %b", c, out_valid, ref_buf.size() != 0); end
            if (out_valid === 1'b1) begin
                checks++; if (out_data !== 4'(nvalid + 1)) begin errors++; $display("FAIL stream_data: got %h want %h", out_data, 4'(nvalid + 1)); end
                if (first < 0) first = c;
                last = c;
                nvalid++;
            end
            @(posedge clk); #1;
        end
        checks++; if (nvalid != 8) begin errors++; $display("FAIL stream_count: got %0d want 8", nvalid); end
        checks++; if (last - first != 7) begin errors++; $display("FAIL stream_bubbles: got span %0d want 7", last - first); end
        checks++; if (words_out !== w0 + 8'd8) begin errors++; $display("FAIL stream_words: got %0d want %0d", words_out, w0 + 8'd8); end
    endtask

    task automatic test_backpressure();
        int pops;
        int n;
        logic [3:0] exp_seq [3];
        exp_seq[0] = 4'hA; exp_seq[1] = 4'hB; exp_seq[2] = 4'hC;
        enable = 1'b1; out_ready = 1'b0;
        fifo.push_back(4'hA); fifo.push_back(4'hB); fifo.push_back(4'hC);
        pops = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++; if (fifo_pop !== exp_pop()) begin errors++; $display("FAIL stall_pop c%0d: got %b want %b", c, fifo_pop, exp_pop()); end
            if (fifo_pop === 1'b1) pops++;
            if (out_valid === 1'b1) begin
                checks++; if (out_data !== 4'hA) begin errors++; $display("FAIL stall_data c%0d: got %h want a", c, out_data); end
            end
            @(posedge clk); #1;
        end
        checks++; if (pops != 2) begin errors++; $display("FAIL stall_pop_count: got %0d want 2", pops); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", out_valid); end
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++; if (fifo_pop !== exp_pop()) begin errors++; $display("FAIL release_pop c%0d: got %b want %b", c, fifo_pop, exp_pop()); end
            if (out_valid === 1'b1) begin
                checks++;
                if (n >= 3) begin errors++; $display("FAIL release_extra: got %h want none", out_data); end
                else if (out_data !== exp_seq[n]) begin errors++; $display("FAIL release_data %0d: got %h want %h", n, out_data, exp_seq[n]); end
                n++;
            end
            @(posedge clk); #1;
        end
        checks++; if (n != 3) begin errors++; $display("FAIL release_count: got %0d want 3", n); end
    endtask

    task automatic test_enable_drop();
        int pops;
        int n;
        bit seen;
        logic [3:0] last_word;
        enable = 1'b1; out_ready = 1'b1;
        fifo.push_back(4'h7); fifo.push_back(4'h9);
        seen = 1'b0; n = 0; last_word = 4'h0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            if (fifo_pop === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL drop_pop_timeout: got no pop want pop within 5 cycles"); end
        enable = 1'b0;
        pops = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL drop_pop c%0d: got %b want 0", c, fifo_pop); end
            if (fifo_pop === 1'b1) pops++;
            if (out_valid === 1'b1) begin n++; last_word = out_data; end
            @(posedge clk); #1;
        end
        checks++; if (n != 1 || last_word !== 4'h7) begin errors++; $display("FAIL drop_deliver: got %0d words last %h want 1 word 7", n, last_word); end
        checks++; if (fifo.size() != 1) begin errors++; $display("FAIL drop_left: got %0d want 1 in fifo", fifo.size()); end
        enable = 1'b1; n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                checks++; if (out_data !== 4'h9) begin errors++; $display("FAIL drop_resume: got %h want 9", out_data); end
                n++;
            end
            @(posedge clk); #1;
        end
        checks++; if (n != 1) begin errors++; $display("FAIL drop_resume_count: got %0d want 1", n); end
    endtask

    task automatic test_random_wrap();
        bit saw_255;
        bit saw_wrap;
        for (int c = 0; c < 3000 && !saw_wrap; c++) begin
            enable    = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if (fifo.size() < 16 && $urandom_range(0, 3) != 0) fifo.push_back(4'($urandom_range(0, 15)));
            @(negedge clk);
            checks++; if (fifo_pop !== exp_pop()) begin errors++; $display("FAIL rnd_pop c%0d: got %b want %b", c, fifo_pop, exp_pop()); end
            checks++; if (out_valid !== (ref_buf.size() != 0)) begin errors++; $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid, ref_buf.size() != 0); end
            if (ref_buf.size() != 0) begin
                checks++; if (out_data !== ref_buf[0]) begin errors++; $display("FAIL rnd_data c%0d: got %h want %h", c, out_data, ref_buf[0]); end
            end
            checks++; if (words_out !== ref_words) begin errors++; $display("FAIL rnd_words c%0d: got %0d want %0d", c, words_out, ref_words); end
            checks++; if (busy !== (ref_inflight || ref_buf.size() != 0)) begin errors++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, ref_inflight || ref_buf.size() != 0); end
            if (ref_words == 8'd255) saw_255 = 1'b1;
            if (saw_255 && ref_words == 8'd0 && words_out === 8'd0) saw_wrap = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (!saw_wrap) begin errors++; $display("FAIL wrap_timeout: got no 255->0 want wrap within 3000 cycles"); end
    endtask

    task automatic test_async_reset();
        enable = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        fifo.delete();
        fifo.push_back(4'h1); fifo.push_back(4'h2); fifo.push_back(4'h3);
        enable = 1'b1; out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (fifo_pop !== exp_pop()) begin errors++; $display("FAIL ar_fill_pop c%0d: got %b want %b", c, fifo_pop, exp_pop()); end
            @(posedge clk); #1;
        end
        checks++; if (ref_buf.size() != 2 || out_valid !== 1'b1) begin errors++; $display("FAIL ar_fill: got valid %b want 1 with 2 buffered", out_valid); end
        @(negedge clk);
        #2;
        fifo.delete();
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", out_valid); end
        checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL ar_pop: got %b want 0", fifo_pop); end
        checks++; if (words_out !== 8'd0) begin errors++; $display("FAIL ar_words: got %0d want 0", words_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy: got %b want 0", busy); end
        @(negedge clk);
        #2;
        reset = 1'b1; out_ready = 1'b1; enable = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_stale c%0d: got valid %b data %h want 0", c, out_valid, out_data); end
            checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL ar_after_pop c%0d: got %b want 0", c, fifo_pop); end
            checks++; if (words_out !== 8'd0) begin errors++; $display("FAIL ar_after_words c%0d: got %0d want 0", c, words_out); end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_enable_drop();
        test_random_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
